plb_responder: RTL

- Small fully-associative Permission Lookaside Buffer (PLB) that acts as the slave end of the PLB MEM/SRAM interface driven by the PLB lookup pipeline stage.
- Read requests perform a tag lookup on the supervisor physical address and return 0x1 on a hit and 0x0 on a miss.
- Write requests from the walker insert or invalidate entries.
- A flush input clears the whole buffer.

---
 rtl/mpt_pkg.sv | 26 ++
 rtl/plb_tag_match.sv | 35 +++
 rtl/plb_responder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mpt_pkg.sv
// Shared PLB definitions: entry layout, write-op encodings and the lookup
// response values that the lookup stage decodes.
package mpt_pkg;

    localparam int unsigned PLB_MEM_ADDR_WIDTH = 64;
    localparam int unsigned PLB_PAGE_SHIFT     = 12;

    typedef struct packed {
        logic                                         valid;
        logic [PLB_MEM_ADDR_WIDTH-PLB_PAGE_SHIFT-1:0] tag;
    } plb_entry_t;

    localparam logic PLB_OP_INVALIDATE = 1'b0;
    localparam logic PLB_OP_INSERT     = 1'b1;

    localparam logic [63:0] PLB_HIT  = 64'h1;
    localparam logic [63:0] PLB_MISS = 64'h0;

    typedef enum logic [1:0] {
        PLB_REQ_LOOKUP,
        PLB_REQ_INSERT,
        PLB_REQ_INVALIDATE,
        PLB_REQ_BAD_BE
    } plb_req_e;

endpackage

// File: rtl/plb_tag_match.sv
// Combinational tag compare across all PLB entries, with lowest-index
// priority for both the match and the first free slot.
module plb_tag_match #(
    parameter int unsigned PLB_ENTRIES = 8,
    parameter int unsigned TAG_W       = 52,
    parameter int unsigned IDX_W       = 3
) (
    input  logic [TAG_W-1:0]                   tag,
    input  logic [PLB_ENTRIES-1:0]             entry_valid,
    input  logic [PLB_ENTRIES-1:0][TAG_W-1:0]  entry_tag,
    output logic                               hit,
    output logic [IDX_W-1:0]                   match_idx,
    output logic                               any_free,
    output logic [IDX_W-1:0]                   free_idx
);

    always_comb begin
        hit       = 1'b0;
        match_idx = '0;
        any_free  = 1'b0;
        free_idx  = '0;
        // Scan high to low so the lowest index is the last one written.
        for (int unsigned i = PLB_ENTRIES; i > 0; i--) begin
            if (entry_valid[i-1] && (entry_tag[i-1] == tag)) begin
                hit       = 1'b1;
                match_idx = IDX_W'(i - 1);
            end
            if (!entry_valid[i-1]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/plb_responder.sv
// Fully-associative Permission Lookaside Buffer acting as the MEM/SRAM slave
// of the PLB lookup stage: lookups answer hit/miss, walker writes fill/invalidate.
module plb_responder
    import mpt_pkg::*;
#(
    parameter int unsigned PLB_ENTRIES    = 8,
    parameter int unsigned MEM_ADDR_WIDTH = 64,
    parameter int unsigned MEM_DATA_WIDTH = 64,
    parameter int unsigned PAGE_SHIFT     = 12,
    parameter int unsigned COUNTER_WIDTH  = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        plb_slave_mem_req,
    output logic                        plb_slave_mem_gnt,
    output logic                        plb_slave_mem_valid,
    input  logic [MEM_ADDR_WIDTH-1:0]   plb_slave_mem_addr,
    output logic [MEM_DATA_WIDTH-1:0]   plb_slave_mem_rdata,
    input  logic [MEM_DATA_WIDTH-1:0]   plb_slave_mem_wdata,
    input  logic                        plb_slave_mem_we,
    input  logic [MEM_DATA_WIDTH/8-1:0] plb_slave_mem_be,
    output logic                        plb_slave_mem_error,
    input  logic                        flush_i,
    output logic [COUNTER_WIDTH-1:0]    hit_count_o,
    output logic [COUNTER_WIDTH-1:0]    miss_count_o
);

    localparam int unsigned TAG_W = MEM_ADDR_WIDTH - PAGE_SHIFT;
    localparam int unsigned IDX_W = $clog2(PLB_ENTRIES);

    logic [PLB_ENTRIES-1:0]            entry_valid;
    logic [PLB_ENTRIES-1:0][TAG_W-1:0] entry_tag;
    logic [IDX_W-1:0]                  repl_ptr;

    logic [TAG_W-1:0] req_tag;
    logic             hit;
    logic [IDX_W-1:0] match_idx;
    logic             any_free;
    logic [IDX_W-1:0] free_idx;
    plb_req_e         req_kind;
    logic             unused_bits;

    assign req_tag           = plb_slave_mem_addr[MEM_ADDR_WIDTH-1:PAGE_SHIFT];
    assign plb_slave_mem_gnt = plb_slave_mem_req && !flush_i && !rst_i;
    assign unused_bits       = ^{plb_slave_mem_wdata[MEM_DATA_WIDTH-1:1],
                                 plb_slave_mem_addr[PAGE_SHIFT-1:0]};

    plb_tag_match #(
        .PLB_ENTRIES (PLB_ENTRIES),
        .TAG_W       (TAG_W),
        .IDX_W       (IDX_W)
    ) u_tag_match (
        .tag         (req_tag),
        .entry_valid (entry_valid),
        .entry_tag   (entry_tag),
        .hit         (hit),
        .match_idx   (match_idx),
        .any_free    (any_free),
        .free_idx    (free_idx)
    );

    always_comb begin
        req_kind = PLB_REQ_LOOKUP;
        if (plb_slave_mem_we) begin
            if (!(&plb_slave_mem_be)) begin
                req_kind = PLB_REQ_BAD_BE;
            end else begin
                case (plb_slave_mem_wdata[0])
                    PLB_OP_INSERT:     req_kind = PLB_REQ_INSERT;
                    PLB_OP_INVALIDATE: req_kind = PLB_REQ_INVALIDATE;
                    default:           req_kind = PLB_REQ_BAD_BE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            entry_valid         <= '0;
            entry_tag           <= '0;
            repl_ptr            <= '0;
            plb_slave_mem_valid <= 1'b0;
            plb_slave_mem_rdata <= '0;
            plb_slave_mem_error <= 1'b0;
            hit_count_o         <= '0;
            miss_count_o        <= '0;
        end else begin
            plb_slave_mem_valid <= plb_slave_mem_gnt;
            if (flush_i) begin
                entry_valid <= '0;
            end else if (plb_slave_mem_gnt) begin
                plb_slave_mem_rdata <= MEM_DATA_WIDTH'(PLB_MISS);
                plb_slave_mem_error <= 1'b0;
                case (req_kind)
                    PLB_REQ_LOOKUP: begin
                        if (hit) begin
                            plb_slave_mem_rdata <= MEM_DATA_WIDTH'(PLB_HIT);
                            if (hit_count_o != '1) hit_count_o <= hit_count_o + 1'b1;
                        end else begin
                            if (miss_count_o != '1) miss_count_o <= miss_count_o + 1'b1;
                        end
                    end
                    PLB_REQ_INSERT: begin
                        if (!hit) begin
                            if (any_free) begin
                                entry_valid[free_idx] <= 1'b1;
                                entry_tag[free_idx]   <= req_tag;
                            end else begin
                                entry_tag[repl_ptr] <= req_tag;
                                repl_ptr            <= repl_ptr + 1'b1;
                            end
                        end
                    end
                    PLB_REQ_INVALIDATE: begin
                        if (hit) entry_valid[match_idx] <= 1'b0;
                    end
                    default: plb_slave_mem_error <= 1'b1;
                endcase
            end
        end
    end

endmodule
